icache: RTL and testbench

//  Direct-mapped instruction cache between the IF stage and memctrl-fed refill path. IF issues a

---
 rtl/icache.sv | 156 +++++++++++++++
 tb/tb_icache.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache with 1-cycle lookup, fill port and invalidate sweep.
// Optional hit/miss statistics counters are compiled in when ICACHE_STAT_EN is defined.
module icache #(
    parameter int INDEX_W = 7,
    parameter int ADDR_W  = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        read_i,
    input  logic [31:0] read_addr_i,
    input  logic        write_i,
    input  logic [31:0] write_addr_i,
    input  logic [31:0] write_inst_i,
    input  logic        flush_i,
    output logic        read_hit_o,
    output logic [31:0] read_inst_o,
    output logic        busy_o
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int DEPTH = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic {
        SWEEP,
        IDLE
    } state_e;

    state_e               state_q, state_d;
    logic [INDEX_W-1:0]   sweep_cnt_q, sweep_cnt_d;
    logic                 hit_q, hit_d;
    logic [31:0]          inst_q, inst_d;

    logic                 valid_q [DEPTH];
    logic [TAG_W-1:0]     tag_q   [DEPTH];
    logic [31:0]          data_q  [DEPTH];

    logic [INDEX_W-1:0]   r_idx, w_idx;
    logic [TAG_W-1:0]     r_tag, w_tag;
    logic                 active;
    logic                 wr_en;
    logic                 sweep_clr;
    logic                 unused_addr_bits;

    assign r_idx = read_addr_i[INDEX_W+1:2];
    assign r_tag = read_addr_i[ADDR_W-1:INDEX_W+2];
    assign w_idx = write_addr_i[INDEX_W+1:2];
    assign w_tag = write_addr_i[ADDR_W-1:INDEX_W+2];
    assign unused_addr_bits = ^{read_addr_i[31:ADDR_W], read_addr_i[1:0],
                                write_addr_i[31:ADDR_W], write_addr_i[1:0]};

    // Requests are only honoured in IDLE and never alongside a flush.
    assign active = (state_q == IDLE) && !flush_i;
    assign wr_en  = rdy && write_i && active;

    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        hit_d       = hit_q;
        inst_d      = inst_q;
        sweep_clr   = 1'b0;
        if (rdy) begin
            hit_d  = 1'b0;
            inst_d = '0;
            case (state_q)
                SWEEP: begin
                    sweep_clr = 1'b1;
                    if (flush_i) begin
                        sweep_cnt_d = '0;
                    end else begin
                        sweep_cnt_d = sweep_cnt_q + 1'b1;
                        if (sweep_cnt_q == {INDEX_W{1'b1}}) begin
                            state_d = IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (flush_i) begin
                        state_d     = SWEEP;
                        sweep_cnt_d = '0;
                    end else if (read_i) begin
                        // A same-cycle fill to this line wins over the stored copy.
                        if (write_i && (w_idx == r_idx)) begin
                            hit_d = (w_tag == r_tag);
                            if (w_tag == r_tag) begin
                                inst_d = write_inst_i;
                            end
                        end else if (valid_q[r_idx] && (tag_q[r_idx] == r_tag)) begin
                            hit_d  = 1'b1;
                            inst_d = data_q[r_idx];
                        end
                    end
                end
                default: begin
                    state_d     = SWEEP;
                    sweep_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SWEEP;
            sweep_cnt_q <= '0;
            hit_q       <= 1'b0;
            inst_q      <= '0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            hit_q       <= hit_d;
            inst_q      <= inst_d;
        end
    end

    // Line storage is RAM-like: no reset, valid bits are cleared by the sweep.
    always_ff @(posedge clk) begin
        if (sweep_clr) begin
            valid_q[sweep_cnt_q] <= 1'b0;
        end else if (wr_en) begin
            valid_q[w_idx] <= 1'b1;
            tag_q[w_idx]   <= w_tag;
            data_q[w_idx]  <= write_inst_i;
        end
    end

    assign read_hit_o  = hit_q;
    assign read_inst_o = inst_q;
    assign busy_o      = (state_q == SWEEP);

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy && read_i) begin
            if (hit_d) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: reset sweep, lookup/fill, replacement, forwarding, flush and freeze.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        read_i;
    logic [31:0] read_addr_i;
    logic        write_i;
    logic [31:0] write_addr_i;
    logic [31:0] write_inst_i;
    logic        flush_i;
    logic        read_hit_o;
    logic [31:0] read_inst_o;
    logic        busy_o;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
    logic [31:0] h0, m0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cycles;

    icache dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .read_i       (read_i),
        .read_addr_i  (read_addr_i),
        .write_i      (write_i),
        .write_addr_i (write_addr_i),
        .write_inst_i (write_inst_i),
        .flush_i      (flush_i),
        .read_hit_o   (read_hit_o),
        .read_inst_o  (read_inst_o),
        .busy_o       (busy_o)
`ifdef ICACHE_STAT_EN
        ,
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        read_i  = 1'b0;
        write_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] addr);
        read_i      = 1'b1;
        read_addr_i = addr;
        step();
        read_i      = 1'b0;
    endtask

    task automatic fill(input logic [31:0] addr, input logic [31:0] inst);
        write_i      = 1'b1;
        write_addr_i = addr;
        write_inst_i = inst;
        step();
        write_i      = 1'b0;
    endtask

    // Counts cycles with busy_o high, sampling before each edge.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy_o) break;
            n++;
            step();
        end
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1;
        read_i = 1'b0; read_addr_i = '0;
        write_i = 1'b0; write_addr_i = '0; write_inst_i = '0;
        flush_i = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_hit", {31'd0, read_hit_o}, 32'd0);
        check("rst_inst", read_inst_o, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd1);
        step();
        step();
        rst = 1'b0;

        count_busy(cycles);
        check("rst_sweep_len", cycles, 32'd128);

        // 1: empty cache misses
        lookup(32'h0);
        check("t1_hit", {31'd0, read_hit_o}, 32'd0);
        check("t1_inst", read_inst_o, 32'd0);

        // 2: fill then hit, idle cycle returns zeros
        fill(32'h10, 32'h00A00093);
        lookup(32'h10);
        check("t2_hit", {31'd0, read_hit_o}, 32'd1);
        check("t2_inst", read_inst_o, 32'h00A00093);
        step();
        check("t2_noread_hit", {31'd0, read_hit_o}, 32'd0);
        check("t2_noread_inst", read_inst_o, 32'd0);

        // 3: replacement on same index, ignored address bits
        fill(32'h210, 32'hDEADBEEF);
        lookup(32'h10);
        check("t3_old_hit", {31'd0, read_hit_o}, 32'd0);
        check("t3_old_inst", read_inst_o, 32'd0);
        lookup(32'h210);
        check("t3_new_hit", {31'd0, read_hit_o}, 32'd1);
        check("t3_new_inst", read_inst_o, 32'hDEADBEEF);
        lookup(32'h20210);
        check("t3_alias_hit", {31'd0, read_hit_o}, 32'd1);
        check("t3_alias_inst", read_inst_o, 32'hDEADBEEF);
        lookup(32'h213);
        check("t3_byteoff_inst", read_inst_o, 32'hDEADBEEF);

        // 4: read+write forwarding
        read_i = 1'b1; read_addr_i = 32'h20;
        fill(32'h20, 32'h12345678);
        check("t4_fwd_hit", {31'd0, read_hit_o}, 32'd1);
        check("t4_fwd_inst", read_inst_o, 32'h12345678);
        lookup(32'h20);
        check("t4_stored_inst", read_inst_o, 32'h12345678);
        read_i = 1'b1; read_addr_i = 32'h220;
        fill(32'h20, 32'h0BADF00D);
        check("t4_fwd_tagdiff_hit", {31'd0, read_hit_o}, 32'd0);
        check("t4_fwd_tagdiff_inst", read_inst_o, 32'd0);

        // 5: flush, dropped write during sweep, re-flush at sweep_cnt=50
        fill(32'h10, 32'h00A00093);
        flush_i = 1'b1;
        step();
        clear_req();
        cycles = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy_o) break;
            cycles++;
            flush_i      = (i == 50);
            write_i      = (i == 4);
            write_addr_i = 32'h40;
            write_inst_i = 32'h55555555;
            read_i       = (i == 1);
            read_addr_i  = 32'h10;
            step();
            if (i == 1) check("t5_sweep_read", {31'd0, read_hit_o}, 32'd0);
        end
        clear_req();
        check("t5_busy_len", cycles, 32'd179);
        lookup(32'h10);
        check("t5_post_10", {31'd0, read_hit_o}, 32'd0);
        lookup(32'h40);
        check("t5_post_40", {31'd0, read_hit_o}, 32'd0);
        lookup(32'h20);
        check("t5_post_20", {31'd0, read_hit_o}, 32'd0);

        // 6: rdy freeze in IDLE, lost requests
        fill(32'h30, 32'hCAFEF00D);
        lookup(32'h30);
        check("t6_pre_hit", {31'd0, read_hit_o}, 32'd1);
        rdy = 1'b0; read_i = 1'b1; read_addr_i = 32'h34;
        write_i = 1'b1; write_addr_i = 32'h34; write_inst_i = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_frz_hit", {31'd0, read_hit_o}, 32'd1);
            check("t6_frz_inst", read_inst_o, 32'hCAFEF00D);
        end
        rdy = 1'b1;
        clear_req();
        lookup(32'h34);
        check("t6_lost_write", {31'd0, read_hit_o}, 32'd0);

`ifdef ICACHE_STAT_EN
        h0 = hit_cnt_o;
        m0 = miss_cnt_o;
        lookup(32'h30);
        lookup(32'h34);
        lookup(32'h30);
        lookup(32'h34);
        lookup(32'h34);
        check("stat_hits", hit_cnt_o - h0, 32'd2);
        check("stat_misses", miss_cnt_o - m0, 32'd3);
`endif

        // rdy low mid-sweep stretches the sweep by the frozen cycles
        flush_i = 1'b1;
        step();
        clear_req();
        cycles = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy_o) break;
            cycles++;
            rdy = !(i >= 10 && i < 13);
            step();
        end
        rdy = 1'b1;
        check("frz_sweep_len", cycles, 32'd131);

        // reset mid-sweep restarts from entry 0
        flush_i = 1'b1;
        step();
        clear_req();
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, busy_o}, 32'd1);
        step();
        rst = 1'b0;
        count_busy(cycles);
        check("rst_mid_sweep_len", cycles, 32'd128);
        lookup(32'h30);
        check("rst_mid_post_hit", {31'd0, read_hit_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
